// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage plus IF/ID pipeline register.
// Issues one instruction-memory request at a time, parks a response in a
// one-entry skid buffer when decode is stalled, and squashes/restarts on
// redirects from EX.
// Optional feature macro: FETCH_PERF_EN adds stall-cycle and squash counters.
module fetch_stage #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    output logic            o_ifid_valid,
    output logic [XLEN-1:0] o_ifid_pc,
    output logic [31:0]     o_ifid_instr
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     o_perf_stall_cycles,
    output logic [31:0]     o_perf_squashed
`endif
);

    localparam logic [31:0]     NOP        = 32'h0000_0013;
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b0}}, 2'b11};
    localparam logic [XLEN-1:0] PC_STEP    = {{(XLEN-3){1'b0}}, 3'b100};

    typedef enum logic [1:0] {
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic [31:0]     buf_instr_q, buf_instr_d;
    logic            ifid_valid_q, ifid_valid_d;
    logic [XLEN-1:0] ifid_pc_q, ifid_pc_d;
    logic [31:0]     ifid_instr_q, ifid_instr_d;

    assign o_imem_req   = (state_q == S_ISSUE) && !i_redirect && !i_rst;
    assign o_imem_addr  = pc_q;
    assign o_ifid_valid = ifid_valid_q;
    assign o_ifid_pc    = ifid_pc_q;
    assign o_ifid_instr = ifid_instr_q;

    // Next-state logic: redirect overrides everything, then the fetch FSM and IF/ID update.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        req_pc_d     = req_pc_q;
        drop_d       = drop_q;
        buf_pc_d     = buf_pc_q;
        buf_instr_d  = buf_instr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_instr_d = ifid_instr_q;

        if (i_redirect) begin
            // The skid buffer counts as full only in S_HOLD, so leaving S_HOLD empties it.
            pc_d         = i_redirect_pc & ~ALIGN_MASK;
            ifid_valid_d = 1'b0;
            drop_d       = 1'b0;
            state_d      = S_ISSUE;
            if ((state_q == S_WAIT) && !i_imem_rvalid) begin
                drop_d  = 1'b1;
                state_d = S_WAIT;
            end
        end else begin
            if (!i_stall) begin
                ifid_valid_d = 1'b0;
            end
            case (state_q)
                S_ISSUE: begin
                    if (i_imem_gnt) begin
                        pc_d     = pc_q + PC_STEP;
                        req_pc_d = pc_q;
                        state_d  = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        if (drop_q) begin
                            drop_d  = 1'b0;
                            state_d = S_ISSUE;
                        end else if (!i_stall || !ifid_valid_q) begin
                            ifid_valid_d = 1'b1;
                            ifid_pc_d    = req_pc_q;
                            ifid_instr_d = i_imem_rdata;
                            state_d      = S_ISSUE;
                        end else begin
                            buf_pc_d    = req_pc_q;
                            buf_instr_d = i_imem_rdata;
                            state_d     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (!i_stall) begin
                        ifid_valid_d = 1'b1;
                        ifid_pc_d    = buf_pc_q;
                        ifid_instr_d = buf_instr_q;
                        state_d      = S_ISSUE;
                    end
                end
                default: state_d = S_ISSUE;
            endcase
        end
    end

    // State register with synchronous reset; reset discards all in-flight work.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_ISSUE;
            pc_q         <= RESET_PC;
            req_pc_q     <= '0;
            drop_q       <= 1'b0;
            buf_pc_q     <= '0;
            buf_instr_q  <= NOP;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= '0;
            ifid_instr_q <= NOP;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            req_pc_q     <= req_pc_d;
            drop_q       <= drop_d;
            buf_pc_q     <= buf_pc_d;
            buf_instr_q  <= buf_instr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_instr_q <= ifid_instr_d;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_squash_q, perf_squash_d;
    logic [31:0] squash_inc;

    assign o_perf_stall_cycles = perf_stall_q;
    assign o_perf_squashed     = perf_squash_q;

    // Count stalled live cycles, plus every response or instruction thrown away.
    always_comb begin
        squash_inc = 32'd0;
        if (i_redirect) begin
            if (ifid_valid_q) begin
                squash_inc = squash_inc + 32'd1;
            end
            if (state_q == S_HOLD) begin
                squash_inc = squash_inc + 32'd1;
            end
            if ((state_q == S_WAIT) && i_imem_rvalid) begin
                squash_inc = squash_inc + 32'd1;
            end
        end else if ((state_q == S_WAIT) && i_imem_rvalid && drop_q) begin
            squash_inc = 32'd1;
        end
        perf_squash_d = perf_squash_q + squash_inc;
        perf_stall_d  = perf_stall_q + ((i_stall && ifid_valid_q) ? 32'd1 : 32'd0);
    end

    // Performance counter registers, wrapping naturally.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            perf_stall_q  <= 32'd0;
            perf_squash_q <= 32'd0;
        end else begin
            perf_stall_q  <= perf_stall_d;
            perf_squash_q <= perf_squash_d;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios followed by randomized traffic for
// fetch_stage. A behavioural memory answers granted requests after a chosen
// delay, and a queue-based model of the instruction stream predicts the
// request handshake and the IF/ID contents.
module tb_fetch_stage;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic            i_stall;
    logic            i_redirect;
    logic [XLEN-1:0] i_redirect_pc;
    logic            o_imem_req;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_gnt;
    logic            i_imem_rvalid;
    logic [31:0]     i_imem_rdata;
    logic            o_ifid_valid;
    logic [XLEN-1:0] o_ifid_pc;
    logic [31:0]     o_ifid_instr;
`ifdef FETCH_PERF_EN
    logic [31:0]     o_perf_stall_cycles;
    logic [31:0]     o_perf_squashed;
`endif

    fetch_stage #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_stall       (i_stall),
        .i_redirect    (i_redirect),
        .i_redirect_pc (i_redirect_pc),
        .o_imem_req    (o_imem_req),
        .o_imem_addr   (o_imem_addr),
        .i_imem_gnt    (i_imem_gnt),
        .i_imem_rvalid (i_imem_rvalid),
        .i_imem_rdata  (i_imem_rdata),
        .o_ifid_valid  (o_ifid_valid),
        .o_ifid_pc     (o_ifid_pc),
        .o_ifid_instr  (o_ifid_instr)
`ifdef FETCH_PERF_EN
        ,
        .o_perf_stall_cycles (o_perf_stall_cycles),
        .o_perf_squashed     (o_perf_squashed)
`endif
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    // Memory side: at most one granted request waiting for its response.
    bit          memPending = 1'b0;
    int          memWait    = 0;
    logic [31:0] memAddr    = '0;

    // Instruction-stream model: granted-but-undelivered PCs in program order.
    logic [31:0] modelQ[$];
    bit          frontArrived = 1'b0;
    logic [31:0] modelNextPc  = RESET_PC;
    bit          expValid     = 1'b0;
    logic [31:0] expPc        = '0;
    logic [31:0] expInstr     = NOP;
    bit          justReset    = 1'b0;

    logic        lastReq;
    logic [31:0] lastAddr;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // One clock cycle: drive inputs, check the request side, clock, update models, check IF/ID.
    task automatic applyStimulus(input bit rst, input bit stall, input bit redir,
                                 input logic [31:0] rpc, input bit gntWant, input int rspDelay);
        bit rv;
        bit gnt;
        bit expReq;
        i_rst         = rst;
        i_stall       = stall;
        i_redirect    = redir;
        i_redirect_pc = rpc;
        rv            = !rst && memPending && (memWait == 0);
        i_imem_rvalid = rv;
        i_imem_rdata  = rv ? memWord(memAddr) : $urandom();
        i_imem_gnt    = 1'b0;
        #1;
        expReq   = !rst && !redir && !memPending && (modelQ.size() == 0);
        lastReq  = o_imem_req;
        lastAddr = o_imem_addr;
        checkOutput("imem_req", {31'b0, o_imem_req}, {31'b0, expReq});
        if (expReq) checkOutput("imem_addr", o_imem_addr, modelNextPc);
        gnt        = o_imem_req && gntWant;
        i_imem_gnt = gnt;

        @(posedge i_clk);

        if (rst) begin
            memPending = 1'b0;
        end else begin
            if (rv) memPending = 1'b0;
            else if (memPending) memWait--;
            if (gnt) begin
                memPending = 1'b1;
                memAddr    = lastAddr;
                memWait    = rspDelay;
            end
        end

        justReset = 1'b0;
        if (rst) begin
            modelQ.delete();
            frontArrived = 1'b0;
            modelNextPc  = RESET_PC;
            expValid     = 1'b0;
            justReset    = 1'b1;
        end else if (redir) begin
            modelQ.delete();
            frontArrived = 1'b0;
            expValid     = 1'b0;
            modelNextPc  = rpc & 32'hFFFF_FFFC;
        end else begin
            if (rv && (modelQ.size() > 0)) frontArrived = 1'b1;
            if (!(stall && expValid)) begin
                if (frontArrived) begin
                    expValid     = 1'b1;
                    expPc        = modelQ.pop_front();
                    expInstr     = memWord(expPc);
                    frontArrived = 1'b0;
                end else begin
                    expValid = 1'b0;
                end
            end
            if (gnt) begin
                modelQ.push_back(modelNextPc);
                modelNextPc = modelNextPc + 32'd4;
            end
        end

        #1;
        checkOutput("ifid_valid", {31'b0, o_ifid_valid}, {31'b0, expValid});
        if (expValid) begin
            checkOutput("ifid_pc", o_ifid_pc, expPc);
            checkOutput("ifid_instr", o_ifid_instr, expInstr);
        end
        if (justReset) begin
            checkOutput("reset_ifid_pc", o_ifid_pc, 32'h0);
            checkOutput("reset_ifid_instr", o_ifid_instr, NOP);
        end
    endtask

    // Directed scenarios, then randomized traffic, then the summary.
    initial begin
        bit          rRst;
        bit          rStall;
        bit          rRedir;
        logic [31:0] rPc;
        i_rst = 1'b1; i_stall = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
        i_imem_gnt = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;

        applyStimulus(1, 0, 0, 32'h0, 0, 0);
        applyStimulus(1, 0, 0, 32'h0, 0, 0);

        // Back-to-back fetch from reset.
        applyStimulus(0, 0, 0, 32'h0, 1, 0);
        checkOutput("t1_req0", {31'b0, lastReq}, 32'h1);
        checkOutput("t1_addr0", lastAddr, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 1, 0);
        checkOutput("t1_ifid_pc0", o_ifid_pc, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 1, 0);
        checkOutput("t1_addr4", lastAddr, 32'h4);
        checkOutput("t1_bubble", {31'b0, o_ifid_valid}, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 1, 0);
        checkOutput("t1_ifid_pc4", o_ifid_pc, 32'h4);
        checkOutput("t1_ifid_instr4", o_ifid_instr, memWord(32'h4));

        // Stall while the next response arrives: it must park and later appear once.
        applyStimulus(0, 1, 0, 32'h0, 1, 0);
        checkOutput("t2_addr8", lastAddr, 32'h8);
        applyStimulus(0, 1, 0, 32'h0, 1, 0);
        checkOutput("t2_hold_pc4", o_ifid_pc, 32'h4);
        applyStimulus(0, 1, 0, 32'h0, 1, 0);
        checkOutput("t2_noreq_hold", {31'b0, lastReq}, 32'h0);
        checkOutput("t2_hold_pc4b", o_ifid_pc, 32'h4);
        applyStimulus(0, 0, 0, 32'h0, 1, 0);
        checkOutput("t2_noreq_release", {31'b0, lastReq}, 32'h0);
        checkOutput("t2_ifid_pc8", o_ifid_pc, 32'h8);
        applyStimulus(0, 0, 0, 32'h0, 1, 2);
        checkOutput("t2_addrC", lastAddr, 32'hC);

        // Redirect while waiting; the late response must be dropped.
        applyStimulus(0, 0, 1, 32'h103, 1, 0);
        checkOutput("t3_squash", {31'b0, o_ifid_valid}, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 1, 0);
        applyStimulus(0, 0, 0, 32'h0, 1, 0);
        checkOutput("t3_drop_valid", {31'b0, o_ifid_valid}, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 1, 0);
        checkOutput("t3_addr100", lastAddr, 32'h100);
        applyStimulus(0, 0, 0, 32'h0, 1, 0);
        checkOutput("t3_ifid_pc100", o_ifid_pc, 32'h100);
        checkOutput("t3_ifid_valid", {31'b0, o_ifid_valid}, 32'h1);

        // Redirect and stall together: redirect wins.
        applyStimulus(0, 1, 1, 32'h200, 1, 0);
        checkOutput("t4_redirect_wins", {31'b0, o_ifid_valid}, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 0, 0);
        checkOutput("t4_addr200", lastAddr, 32'h200);

        // PC wrap at the top of the address space.
        applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        applyStimulus(0, 0, 0, 32'h0, 1, 0);
        checkOutput("t5_addr_top", lastAddr, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 32'h0, 1, 0);
        checkOutput("t5_ifid_top", o_ifid_pc, 32'hFFFF_FFFC);
        applyStimulus(0, 0, 0, 32'h0, 1, 0);
        checkOutput("t5_addr_wrap", lastAddr, 32'h0);
        applyStimulus(0, 0, 0, 32'h0, 1, 0);

        // Reset while a stalled response sits in the skid buffer.
        applyStimulus(0, 1, 0, 32'h0, 1, 0);
        applyStimulus(0, 1, 0, 32'h0, 1, 0);
        applyStimulus(1, 1, 0, 32'h0, 1, 0);
        checkOutput("t6_reset_valid", {31'b0, o_ifid_valid}, 32'h0);
        applyStimulus(0, 1, 0, 32'h0, 0, 0);
        checkOutput("t6_req_after_reset", {31'b0, lastReq}, 32'h1);
        checkOutput("t6_addr_reset_pc", lastAddr, RESET_PC);

        // Randomized traffic against the stream model.
        for (int i = 0; i < 3000; i++) begin
            rRst   = ($urandom_range(0, 199) == 0);
            rStall = ($urandom_range(0, 2) == 0);
            rRedir = ($urandom_range(0, 11) == 0);
            rPc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom() & 32'hF))
                                                 : ($urandom() & 32'h0000_0FFF);
            applyStimulus(rRst, rStall, rRedir, rPc, ($urandom_range(0, 3) != 0), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
